// File: rtl/hazard_stall_controller.sv
// hazard_stall_controller
// Pipeline sequencing controller for the 5-stage RISC-V core. It sits beside
// the EX-stage forwarding unit and covers the hazards forwarding cannot:
// load-use, branch-in-ID operand dependencies (1 or 2 stall cycles) and
// multi-cycle MUL/DIV occupancy of EX.
//
// Optional feature macro: HAZ_PERF_CNT_EN (stall/flush performance counters).
// With it undefined, Stall_Cnt_o / Flush_Cnt_o are tied to zero.
//
// Parameters:
//   MD_TIMEOUT  cycles allowed in MD_WAIT before abort (legal 2..255)
//   CNT_W       performance counter width
//
// Ports:
//   clk_i, rst_i              clock (rising edge), async active-low reset
//   ID_*                      operand/branch info of the instruction in ID
//   EX_*, MEM_*               producer info of the instructions in EX and MEM
//   EX_MulDiv_i, MD_Done_i    MUL/DIV in EX, unit result-valid pulse
//   PC_Write_o, IF_ID_Write_o pipeline-register write enables
//   IF_ID_Flush_o             zero IF/ID on the next edge (taken branch)
//   ID_EX_Bubble_o            load NOP into ID/EX
//   EX_Hold_o                 freeze ID/EX while MUL/DIV occupies EX
//   EX_MEM_Bubble_o           load NOP into EX/MEM
//   MD_Start_o                single-cycle start pulse to MUL/DIV
//   MD_Error_o                sticky MUL/DIV timeout flag
//   Stall_Cnt_o, Flush_Cnt_o  performance counters
//   State_o                   debug view of the FSM state (0 RUN, 1 BR_WAIT, 2 MD_WAIT)
//
// Handshake: there is no valid/ready pair here; MD_Start_o is a one-cycle
// request pulse and MD_Done_i a one-cycle completion pulse that is only
// observed while in MD_WAIT.

module hazard_stall_controller #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [4:0]       ID_Rs1_i,
  input  logic [4:0]       ID_Rs2_i,
  input  logic             ID_UseRs1_i,
  input  logic             ID_UseRs2_i,
  input  logic             ID_Branch_i,
  input  logic             ID_BranchTaken_i,
  input  logic             EX_RegWrite_i,
  input  logic             EX_MemRead_i,
  input  logic [4:0]       EX_Rd_i,
  input  logic             MEM_MemRead_i,
  input  logic [4:0]       MEM_Rd_i,
  input  logic             EX_MulDiv_i,
  input  logic             MD_Done_i,
  output logic             PC_Write_o,
  output logic             IF_ID_Write_o,
  output logic             IF_ID_Flush_o,
  output logic             ID_EX_Bubble_o,
  output logic             EX_Hold_o,
  output logic             EX_MEM_Bubble_o,
  output logic             MD_Start_o,
  output logic             MD_Error_o,
  output logic [CNT_W-1:0] Stall_Cnt_o,
  output logic [CNT_W-1:0] Flush_Cnt_o,
  output logic [1:0]       State_o
);

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    BR_WAIT = 2'd1,
    MD_WAIT = 2'd2
  } state_e;

  // Last MD_WAIT counter value before the wait is abandoned.
  localparam logic [7:0] MD_LAST = 8'(MD_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] md_cnt_q, md_cnt_d;
  logic       md_err_q, md_err_d;

  logic hit_ex, hit_mem;

  // Register-zero never creates a dependency; only operands the ID
  // instruction actually reads are considered.
  always_comb begin
    hit_ex  = (ID_UseRs1_i & (ID_Rs1_i != 5'd0) & (ID_Rs1_i == EX_Rd_i) & EX_RegWrite_i)
            | (ID_UseRs2_i & (ID_Rs2_i != 5'd0) & (ID_Rs2_i == EX_Rd_i) & EX_RegWrite_i);
    hit_mem = (ID_UseRs1_i & (ID_Rs1_i != 5'd0) & (ID_Rs1_i == MEM_Rd_i) & MEM_MemRead_i)
            | (ID_UseRs2_i & (ID_Rs2_i != 5'd0) & (ID_Rs2_i == MEM_Rd_i) & MEM_MemRead_i);
  end

  always_comb begin
    PC_Write_o      = 1'b1;
    IF_ID_Write_o   = 1'b1;
    IF_ID_Flush_o   = 1'b0;
    ID_EX_Bubble_o  = 1'b0;
    EX_Hold_o       = 1'b0;
    EX_MEM_Bubble_o = 1'b0;
    MD_Start_o      = 1'b0;
    state_d         = state_q;
    md_cnt_d        = md_cnt_q;
    md_err_d        = md_err_q;

    case (state_q)
      RUN: begin
        if (EX_MulDiv_i) begin
          MD_Start_o      = 1'b1;
          EX_Hold_o       = 1'b1;
          EX_MEM_Bubble_o = 1'b1;
          PC_Write_o      = 1'b0;
          IF_ID_Write_o   = 1'b0;
          md_cnt_d        = 8'd0;
          state_d         = MD_WAIT;
        end else if (ID_Branch_i & hit_ex & EX_MemRead_i) begin
          // Load result is needed in ID: one stall here, one more in BR_WAIT.
          PC_Write_o     = 1'b0;
          IF_ID_Write_o  = 1'b0;
          ID_EX_Bubble_o = 1'b1;
          state_d        = BR_WAIT;
        end else if ((EX_MemRead_i & hit_ex) | (ID_Branch_i & hit_ex) |
                     (ID_Branch_i & hit_mem)) begin
          PC_Write_o     = 1'b0;
          IF_ID_Write_o  = 1'b0;
          ID_EX_Bubble_o = 1'b1;
        end else if (ID_BranchTaken_i) begin
          // Branch outcome is only trustworthy when nothing stalls it.
          IF_ID_Flush_o = 1'b1;
        end
      end

      BR_WAIT: begin
        PC_Write_o     = 1'b0;
        IF_ID_Write_o  = 1'b0;
        ID_EX_Bubble_o = 1'b1;
        state_d        = RUN;
      end

      MD_WAIT: begin
        PC_Write_o      = 1'b0;
        IF_ID_Write_o   = 1'b0;
        EX_Hold_o       = 1'b1;
        EX_MEM_Bubble_o = 1'b1;
        md_cnt_d        = (md_cnt_q == 8'hFF) ? md_cnt_q : md_cnt_q + 8'd1;
        if (MD_Done_i) begin
          // Done wins over a coincident timeout.
          EX_Hold_o       = 1'b0;
          EX_MEM_Bubble_o = 1'b0;
          state_d         = RUN;
        end else if (md_cnt_q == MD_LAST) begin
          EX_Hold_o       = 1'b0;
          EX_MEM_Bubble_o = 1'b0;
          md_err_d        = 1'b1;
          state_d         = RUN;
        end
      end

      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      md_cnt_q <= 8'd0;
      md_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
      md_err_q <= md_err_d;
    end
  end

  assign MD_Error_o = md_err_q;
  assign State_o    = state_q;

`ifdef HAZ_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PC_Write_o)   stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (IF_ID_Flush_o) flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign Stall_Cnt_o = stall_cnt_q;
  assign Flush_Cnt_o = flush_cnt_q;
`else
  assign Stall_Cnt_o = '0;
  assign Flush_Cnt_o = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_controller.sv
// Bench for hazard_stall_controller. Two instances share every input:
// dut_m uses the default MD_TIMEOUT, dut_t uses MD_TIMEOUT = 4 so the abort
// path is reachable next to a 10-cycle MUL/DIV on dut_m.
// Driver applies one directed vector per cycle (#1 after the rising edge) and
// pushes the hand-computed response; the monitor pops and compares on the
// falling edge.

module tb_hazard_stall_controller;

  localparam int CNT_W = 32;
  localparam int EXP_W = 16 + 2 * CNT_W;

  // Output encoding: {PC_Write, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
  //                   EX_Hold, EX_MEM_Bubble, MD_Start, MD_Error}
  localparam logic [7:0] O_RUN   = 8'b1100_0000;
  localparam logic [7:0] O_STALL = 8'b0001_0000;
  localparam logic [7:0] O_FLUSH = 8'b1110_0000;
  localparam logic [7:0] O_MDST  = 8'b0000_1110;
  localparam logic [7:0] O_MDH   = 8'b0000_1100;
  localparam logic [7:0] O_REL   = 8'b0000_0000;
  localparam logic [7:0] O_ERR   = 8'b0000_0001;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       use1;
    logic       use2;
    logic       br;
    logic       taken;
    logic       ex_rw;
    logic       ex_mr;
    logic [4:0] ex_rd;
    logic       mem_mr;
    logic [4:0] mem_rd;
    logic       muldiv;
    logic       done;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk, rst_i;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUT signals ----------------
  vec_t v_in;
  logic pc_m, ifw_m, fl_m, bub_m, hold_m, exb_m, st_m, err_m;
  logic pc_t, ifw_t, fl_t, bub_t, hold_t, exb_t, st_t, err_t;
  logic [CNT_W-1:0] sc_m, fc_m, sc_t, fc_t;
  logic [1:0] state_m, state_t;

  hazard_stall_controller #(.MD_TIMEOUT(64), .CNT_W(CNT_W)) dut_m (
    .clk_i(clk), .rst_i(rst_i),
    .ID_Rs1_i(v_in.rs1), .ID_Rs2_i(v_in.rs2),
    .ID_UseRs1_i(v_in.use1), .ID_UseRs2_i(v_in.use2),
    .ID_Branch_i(v_in.br), .ID_BranchTaken_i(v_in.taken),
    .EX_RegWrite_i(v_in.ex_rw), .EX_MemRead_i(v_in.ex_mr), .EX_Rd_i(v_in.ex_rd),
    .MEM_MemRead_i(v_in.mem_mr), .MEM_Rd_i(v_in.mem_rd),
    .EX_MulDiv_i(v_in.muldiv), .MD_Done_i(v_in.done),
    .PC_Write_o(pc_m), .IF_ID_Write_o(ifw_m), .IF_ID_Flush_o(fl_m),
    .ID_EX_Bubble_o(bub_m), .EX_Hold_o(hold_m), .EX_MEM_Bubble_o(exb_m),
    .MD_Start_o(st_m), .MD_Error_o(err_m),
    .Stall_Cnt_o(sc_m), .Flush_Cnt_o(fc_m), .State_o(state_m)
  );

  hazard_stall_controller #(.MD_TIMEOUT(4), .CNT_W(CNT_W)) dut_t (
    .clk_i(clk), .rst_i(rst_i),
    .ID_Rs1_i(v_in.rs1), .ID_Rs2_i(v_in.rs2),
    .ID_UseRs1_i(v_in.use1), .ID_UseRs2_i(v_in.use2),
    .ID_Branch_i(v_in.br), .ID_BranchTaken_i(v_in.taken),
    .EX_RegWrite_i(v_in.ex_rw), .EX_MemRead_i(v_in.ex_mr), .EX_Rd_i(v_in.ex_rd),
    .MEM_MemRead_i(v_in.mem_mr), .MEM_Rd_i(v_in.mem_rd),
    .EX_MulDiv_i(v_in.muldiv), .MD_Done_i(v_in.done),
    .PC_Write_o(pc_t), .IF_ID_Write_o(ifw_t), .IF_ID_Flush_o(fl_t),
    .ID_EX_Bubble_o(bub_t), .EX_Hold_o(hold_t), .EX_MEM_Bubble_o(exb_t),
    .MD_Start_o(st_t), .MD_Error_o(err_t),
    .Stall_Cnt_o(sc_t), .Flush_Cnt_o(fc_t), .State_o(state_t)
  );

  logic [7:0] obs_m, obs_t;
  assign obs_m = {pc_m, ifw_m, fl_m, bub_m, hold_m, exb_m, st_m, err_m};
  assign obs_t = {pc_t, ifw_t, fl_t, bub_t, hold_t, exb_t, st_t, err_t};

  // ---------------- scoreboard ----------------
  logic [EXP_W-1:0] exp_q[$];
  int n_vec = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [CNT_W-1:0] mdl_sc = '0;
  logic [CNT_W-1:0] mdl_fc = '0;

  task automatic chk(input string name, input int idx,
                     input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  int mon_idx = 0;
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [EXP_W-1:0] e;
      e = exp_q.pop_front();
      chk("outs_m",  mon_idx, CNT_W'(obs_m), CNT_W'(e[EXP_W-1 -: 8]));
      chk("outs_t",  mon_idx, CNT_W'(obs_t), CNT_W'(e[EXP_W-9 -: 8]));
      chk("stall_cnt", mon_idx, sc_m, e[2*CNT_W-1 -: CNT_W]);
      chk("flush_cnt", mon_idx, fc_m, e[CNT_W-1:0]);
      mon_idx++;
    end
  end

  // ---------------- driver ----------------
  // Counter expectations: values visible during this vector, then advanced
  // by this vector's expected stall/flush (zero while reset is held).
  task automatic step(input vec_t v, input logic r,
                      input logic [7:0] em, input logic [7:0] et);
    logic [CNT_W-1:0] esc, efc;
    @(posedge clk);
    #1;
    v_in  = v;
    rst_i = r;
`ifdef HAZ_PERF_CNT_EN
    if (!r) begin
      mdl_sc = '0;
      mdl_fc = '0;
    end
    esc = mdl_sc;
    efc = mdl_fc;
    if (r) begin
      if (!em[7]) mdl_sc = mdl_sc + 1;
      if (em[5])  mdl_fc = mdl_fc + 1;
    end
`else
    esc = '0;
    efc = '0;
`endif
    exp_q.push_back({em, et, esc, efc});
    n_vec++;
  endtask

  initial begin
    vec_t v;
    rst_i = 1'b0;
    v_in  = '0;

    // reset and idle
    v = '0;
    step(v, 1'b0, O_RUN, O_RUN);
    step(v, 1'b1, O_RUN, O_RUN);

    // load-use on rs1 (x5): one stall, then the load sits in MEM with no stall
    v = '0; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5; v.rs1 = 5; v.use1 = 1;
    step(v, 1'b1, O_STALL, O_STALL);
    v = '0; v.mem_mr = 1; v.mem_rd = 5; v.rs1 = 5; v.use1 = 1;
    step(v, 1'b1, O_RUN, O_RUN);

    // same registers but rs1 not read: no stall
    v = '0; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5; v.rs1 = 5; v.use1 = 0;
    step(v, 1'b1, O_RUN, O_RUN);

    // load-use on rs2 (x12)
    v = '0; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 12; v.rs2 = 12; v.use2 = 1; v.rs1 = 12;
    step(v, 1'b1, O_STALL, O_STALL);
    v = '0;
    step(v, 1'b1, O_RUN, O_RUN);

    // zero register never stalls
    v = '0; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 0; v.use1 = 1; v.use2 = 1;
    step(v, 1'b1, O_RUN, O_RUN);

    // ALU producer feeding a non-branch: forwarded, no stall
    v = '0; v.ex_rw = 1; v.ex_rd = 4; v.rs1 = 4; v.use1 = 1;
    step(v, 1'b1, O_RUN, O_RUN);

    // load (x7) feeding beq rs2: stall in RUN, stall in BR_WAIT, then flush once
    v = '0; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 7; v.br = 1; v.rs1 = 1; v.use1 = 1;
    v.rs2 = 7; v.use2 = 1; v.taken = 1;
    step(v, 1'b1, O_STALL, O_STALL);
    v = '0; v.mem_mr = 1; v.mem_rd = 7; v.br = 1; v.rs1 = 1; v.use1 = 1;
    v.rs2 = 7; v.use2 = 1; v.taken = 1;
    step(v, 1'b1, O_STALL, O_STALL);
    v = '0; v.br = 1; v.rs1 = 1; v.use1 = 1; v.rs2 = 7; v.use2 = 1; v.taken = 1;
    step(v, 1'b1, O_FLUSH, O_FLUSH);
    v = '0;
    step(v, 1'b1, O_RUN, O_RUN);

    // ALU producer (x3) feeding a branch: one stall, then not-taken proceeds
    v = '0; v.ex_rw = 1; v.ex_rd = 3; v.br = 1; v.rs1 = 3; v.use1 = 1; v.taken = 1;
    step(v, 1'b1, O_STALL, O_STALL);
    v = '0; v.mem_rd = 3; v.br = 1; v.rs1 = 3; v.use1 = 1;
    step(v, 1'b1, O_RUN, O_RUN);

    // load in MEM (x9) feeding a branch: one stall, then taken flush
    v = '0; v.mem_mr = 1; v.mem_rd = 9; v.br = 1; v.rs1 = 9; v.use1 = 1; v.taken = 1;
    step(v, 1'b1, O_STALL, O_STALL);
    v = '0; v.br = 1; v.rs1 = 9; v.use1 = 1; v.taken = 1;
    step(v, 1'b1, O_FLUSH, O_FLUSH);

    // MD_Done outside MD_WAIT is ignored
    v = '0; v.done = 1;
    step(v, 1'b1, O_RUN, O_RUN);

    // MUL/DIV outranks a load-use hazard; done on the first wait cycle
    v = '0; v.muldiv = 1; v.ex_rw = 1; v.ex_mr = 1; v.ex_rd = 5; v.rs1 = 5; v.use1 = 1;
    v.taken = 1;
    step(v, 1'b1, O_MDST, O_MDST);
    v = '0; v.done = 1;
    step(v, 1'b1, O_REL, O_REL);
    v = '0;
    step(v, 1'b1, O_RUN, O_RUN);

    // done on the 4th wait cycle: coincides with dut_t timeout, no error
    v = '0; v.muldiv = 1;
    step(v, 1'b1, O_MDST, O_MDST);
    v = '0;
    for (int i = 0; i < 3; i++) step(v, 1'b1, O_MDH, O_MDH);
    v.done = 1;
    step(v, 1'b1, O_REL, O_REL);
    v = '0;
    step(v, 1'b1, O_RUN, O_RUN);

    // 10-cycle MUL/DIV on dut_m; dut_t aborts after 4 wait cycles
    v = '0; v.muldiv = 1;
    step(v, 1'b1, O_MDST, O_MDST);
    v = '0;
    for (int i = 0; i < 3; i++) step(v, 1'b1, O_MDH, O_MDH);
    step(v, 1'b1, O_MDH, O_REL);
    for (int i = 0; i < 5; i++) step(v, 1'b1, O_MDH, O_RUN | O_ERR);
    v.done = 1;
    step(v, 1'b1, O_REL, O_RUN | O_ERR);
    v = '0;
    step(v, 1'b1, O_RUN, O_RUN | O_ERR);
    step(v, 1'b1, O_RUN, O_RUN | O_ERR);

    // reset asserted mid-MD_WAIT: immediate return to reset outputs
    v = '0; v.muldiv = 1;
    step(v, 1'b1, O_MDST, O_MDST | O_ERR);
    v = '0;
    step(v, 1'b1, O_MDH, O_MDH | O_ERR);
    step(v, 1'b1, O_MDH, O_MDH | O_ERR);
    step(v, 1'b0, O_RUN, O_RUN);
    step(v, 1'b0, O_RUN, O_RUN);
    v.done = 1;
    step(v, 1'b1, O_RUN, O_RUN);
    v = '0;
    step(v, 1'b1, O_RUN, O_RUN);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Pipeline sequencing controller for the 5-stage RISC-V core; sits beside the EX-stage forwarding unit and decides stalls, bubbles, holds and flushes.
- Covers what forwarding cannot resolve: load-use, branch-in-ID operand dependencies (1 or 2 stall cycles), and multi-cycle MUL/DIV occupancy of EX.
- Drives the PC, IF/ID, ID/EX and EX/MEM pipeline-register enables.

Parameters:
- MD_TIMEOUT, 64: max cycles in MD_WAIT before abort; legal range 2..255.
- CNT_W, 32: width of the performance counters.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- ID_Rs1_i  in  5  rs1 of the instruction in ID
- ID_Rs2_i  in  5  rs2 of the instruction in ID
- ID_UseRs1_i  in  1  ID instruction reads rs1
- ID_UseRs2_i  in  1  ID instruction reads rs2
- ID_Branch_i  in  1  ID instruction is a branch; compares in ID
- ID_BranchTaken_i  in  1  ID branch resolved taken; valid only when no stall
- EX_RegWrite_i  in  1  EX instruction writes rd
- EX_MemRead_i  in  1  EX instruction is a load
- EX_Rd_i  in  5  rd in EX
- MEM_MemRead_i  in  1  MEM instruction is a load
- MEM_Rd_i  in  5  rd in MEM
- EX_MulDiv_i  in  1  EX instruction is MUL/DIV
- MD_Done_i  in  1  MUL/DIV unit result valid, 1-cycle pulse
- PC_Write_o  out  1  PC update enable
- IF_ID_Write_o  out  1  IF/ID register enable
- IF_ID_Flush_o  out  1  zero IF/ID on next edge
- ID_EX_Bubble_o  out  1  load NOP into ID/EX
- EX_Hold_o  out  1  freeze ID/EX
- EX_MEM_Bubble_o  out  1  load NOP into EX/MEM
- MD_Start_o  out  1  start pulse to MUL/DIV unit
- MD_Error_o  out  1  sticky timeout flag
- Stall_Cnt_o  out  CNT_W  stall-cycle counter
- Flush_Cnt_o  out  CNT_W  flush counter

Behaviour:
- Dependency definitions:
  - matchEX(r) = r != 0 & r == EX_Rd_i & EX_RegWrite_i.
  - matchMEM(r) = r != 0 & r == MEM_Rd_i & MEM_MemRead_i.
  - usedHit applies each match only to operands flagged by ID_UseRs1_i / ID_UseRs2_i.
- States: RUN, BR_WAIT, MD_WAIT. A 2-bit state register and an 8-bit MD counter update on the clock; all enables are combinational from state and inputs.
- Reset (rst_i = 0, immediate, asynchronous):
  - state = RUN, MD counter = 0, MD_Error_o = 0, counters = 0.
  - With all inputs 0: PC_Write_o = 1, IF_ID_Write_o = 1, every other output 0.
- "stall" means PC_Write_o = 0, IF_ID_Write_o = 0, ID_EX_Bubble_o = 1.
- RUN, priority high to low:
  1. EX_MulDiv_i = 1: MD_Start_o = 1 for this cycle only; EX_Hold_o = 1; EX_MEM_Bubble_o = 1; PC_Write_o = 0; IF_ID_Write_o = 0; next state MD_WAIT; MD counter cleared.
  2. ID_Branch_i & usedHit(matchEX) & EX_MemRead_i: stall; next state BR_WAIT. Load feeding a branch takes 2 stalls total.
  3. Load-use: EX_MemRead_i & usedHit(matchEX), or ID_Branch_i & usedHit(matchEX), or ID_Branch_i & usedHit(matchMEM): stall for 1 cycle; stay in RUN.
  4. ID_BranchTaken_i: IF_ID_Flush_o = 1.
  5. Otherwise all enables 1, no bubble.
- BR_WAIT: stall unconditionally for one cycle, then RUN. ID_BranchTaken_i is ignored in this state; the branch re-evaluates in RUN.
- MD_WAIT:
  - Every cycle: EX_Hold_o = 1, EX_MEM_Bubble_o = 1, PC_Write_o = 0, IF_ID_Write_o = 0, MD counter increments. The counter saturates at 255 and never wraps.
  - On MD_Done_i: EX_Hold_o = 0, EX_MEM_Bubble_o = 0 (result enters EX/MEM); next state RUN.
  - When the counter == MD_TIMEOUT-1 without done: MD_Error_o is set (sticky until reset); same release as done; next state RUN.
  - MD_Done_i coinciding with timeout: treated as done, no error.
  - MD_Start_o is never asserted in MD_WAIT. Flush is never asserted in BR_WAIT or MD_WAIT.
- MD_Done_i outside MD_WAIT: ignored.
- Reset asserted mid-MD_WAIT: abort to RUN; no MD_Start_o is re-issued.

Optional Feature:
- HAZ_PERF_CNT_EN defined:
  - Stall_Cnt_o increments on every cycle with PC_Write_o = 0.
  - Flush_Cnt_o increments on every cycle with IF_ID_Flush_o = 1.
  - Both wrap modulo 2^CNT_W.
- Undefined: both outputs are constant 0 and no counter flops exist.

Test Plan:
- Load-use: EX load rd = x5, ID add uses rs1 = x5 -> exactly 1 cycle with PC_Write_o = 0 and ID_EX_Bubble_o = 1, then all enables 1.
- Zero register: EX load rd = x0, ID reads x0 -> no stall.
- Load feeding branch: EX load rd = x7, ID beq uses rs2 = x7 -> 2 stall cycles (RUN then BR_WAIT); taken branch then flushes once (IF_ID_Flush_o = 1 for 1 cycle).
- MUL/DIV: EX_MulDiv_i = 1, MD_Done_i 10 cycles later -> MD_Start_o is a single 1-cycle pulse; 10 hold cycles; release in the done cycle; Stall_Cnt_o = 11 with HAZ_PERF_CNT_EN.
- Timeout: MD_TIMEOUT = 4, no done -> release after 4 cycles in MD_WAIT; MD_Error_o = 1 and stays 1 until rst_i is pulsed low.
- Reset mid-MD_WAIT: pull rst_i low asynchronously -> outputs return to reset values immediately, with no clock edge needed.
